frobenius_norm_stream: RTL and testbench
========================================

# frobenius_norm_stream

Streaming Frobenius-norm normaliser for signed fixed-point tensors of run-time length 1..MAX_LEN, parametrised in data width and maximum tensor length.
- Buffers one tensor and accumulates the sum of squares.
- Computes the norm with a bit-serial integer square root, then a reciprocal with a bit-serial divider.
- Replays the tensor scaled by the reciprocal.
- Sits between an upstream valid/ready tensor stream and downstream consumers; one tensor in flight at a time.

## Interface
- DATA_W, 16: element width, signed two's complement; fractional scaling cancels, so it does not affect results.
- MAX_LEN, 256: buffer depth and maximum tensor length.
- LEN_W, $clog2(MAX_LEN)+1: derived; element counter width.
- ACC_W, 2*DATA_W+LEN_W rounded up to even: derived; sum-of-squares width.
- ROOT_W, ACC_W/2: derived; norm width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an input element.
- in_data  in  DATA_W  signed input element.
- in_last  in  1  marks the final element of a tensor.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts an output element.
- out_data  out  DATA_W  signed result, Q2.(DATA_W-2); 1.0 = 2^(DATA_W-2).
- out_last  out  1  marks the final output element.
- busy  out  1  high in every state except ACCUM with count 0.
- overflow  out  1  current/last tensor was truncated at MAX_LEN.
- zero_norm  out  1  current/last tensor had sum of squares 0.

## Operation
- States: ACCUM, SQRT, RECIP, EMIT.
- ACCUM:
  - in_ready=1.
  - Each handshake writes in_data to buf[cnt], adds in_data*in_data to acc, and increments cnt.
  - The tensor ends on in_last, or when element MAX_LEN is accepted (implicit last; overflow set).
  - Then: len<=cnt, clear overflow/zero_norm for the new tensor except as set here, go to SQRT.
- SQRT:
  - Non-restoring integer square root, one result bit per cycle, MSB first.
  - norm = floor(sqrt(acc)), ROOT_W cycles.
  - If norm==0: zero_norm<=1 and go straight to EMIT, with R treated as 0.
- RECIP:
  - Restoring division, one quotient bit per cycle.
  - R = floor(2^(DATA_W-2+ROOT_W) / norm), ROOT_W+DATA_W-1 cycles.
- EMIT:
  - Reads buf[0..len-1] in order.
  - y = (buf[i]*R) >>> ROOT_W, arithmetic shift, i.e. floor.
  - |x| <= norm always holds, so |y| <= 2^(DATA_W-2); no saturation is needed.
  - out_last is asserted with element len-1.
  - After that element's handshake: clear acc and cnt, go to ACCUM.
- in_ready is 0 in SQRT, RECIP and EMIT; upstream input is held off.
- overflow and zero_norm hold their value until the next tensor's ACCUM completes.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, overflow=0, zero_norm=0, state=ACCUM, acc=0, cnt=0.
- ACCUM: one element per cycle.
- SQRT: exactly ROOT_W cycles; RECIP: exactly ROOT_W+DATA_W-1 cycles.
- EMIT pipeline:
  - Registered buffer read, then registered multiply/shift into the output register.
  - First out_valid 2 cycles after EMIT entry.
- With out_ready held high: one element per cycle, no bubbles.
- When out_valid && !out_ready:
  - The entire EMIT pipeline stalls.
  - out_data and out_last stay stable, and out_valid stays high, until accepted.
- The cycle after the last output handshake: state=ACCUM, in_ready=1.
- rst asserted mid-operation: all state returns to reset values immediately; a partial tensor is discarded and buffer contents are don't-care.
- Length 1 tensor: valid; output is ±1.0 per the floor rule.

## Configuration
- FROBNORM_NORM_OUT_EN defined:
  - Adds output norm_out [ROOT_W] and output norm_valid [1].
  - norm_valid pulses for one cycle on SQRT exit, with norm_out = norm.
  - norm_out holds its value until the next SQRT exit; reset value 0.
- FROBNORM_NORM_OUT_EN undefined: both ports and their registers are absent; all other behaviour is identical.

## Test plan
All cases use DATA_W=16, MAX_LEN=256, so ROOT_W=21.
- Tensor {3,4}, in_last on 4, out_ready=1:
  - out_data 9830 then 13107, out_last on the second element.
  - First out_valid 2+21+36=59 cycles after the in_last handshake.
- Tensor {-3,4}: out_data -9831, 13107 (floor rounding on negatives).
- Single-element tensors:
  - {-7}: out_data -16384 with out_last.
  - {7}: out_data 16383.
- All-zero tensor {0,0,0}: zero_norm=1; out_data 0,0,0; RECIP skipped; norm_out=0 when FROBNORM_NORM_OUT_EN is defined.
- 300 elements of value 1 with no in_last:
  - in_ready drops after element 256; overflow=1.
  - 256 outputs, each 1024 (norm 16).
  - Remaining 44 inputs are accepted only as the next tensor once ACCUM resumes.
- Backpressure and reset:
  - Toggle out_ready 1/0 every cycle during {3,4}: outputs are unchanged and stable while stalled.
  - Assert rst during RECIP: all outputs return to reset values, and a following {3,4} gives 9830/13107.

Source files
------------

// File: rtl/frobenius_norm_stream.sv
// Streaming Frobenius-norm normaliser; FROBNORM_NORM_OUT_EN adds norm_out/norm_valid.
// Latency: ROOT_W sqrt + ROOT_W+DATA_W-1 divide + 2 pipeline cycles after the last input.
// Backpressure: in_ready low outside ACCUM; out stall freezes the whole EMIT pipeline.
module frobenius_norm_stream #(
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int ACC_W   = ((2 * DATA_W + LEN_W + 1) / 2) * 2,
  parameter int ROOT_W  = ACC_W / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overflow,
  output logic              zero_norm
`ifdef FROBNORM_NORM_OUT_EN
  ,
  output logic [ROOT_W-1:0] norm_out,
  output logic              norm_valid
`endif
);

  localparam int Q_W    = ROOT_W + DATA_W - 1;
  localparam int R_W    = ROOT_W + 5;
  localparam int REM_W  = ROOT_W + 1;
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IT_W   = $clog2(Q_W + 1);

  typedef enum logic [1:0] {ACCUM, SQRT, RECIP, EMIT} state_t;

  state_t                    state;
  logic [ACC_W-1:0]          acc, sq_d, sq_ext, acc_sum;
  logic [LEN_W-1:0]          cnt, len, rd_idx;
  logic [R_W-1:0]            sq_r, r_sh, r_new;
  logic [ROOT_W-1:0]         sq_q, q_new, norm;
  logic [REM_W-1:0]          rem, rem_sh;
  logic [Q_W-1:0]            recip;
  logic [IT_W-1:0]           it;
  logic [DATA_W-1:0]         rd_dat;
  logic                      s1_vld, s1_last, adv, rd_en, in_hs, last_in;
  logic signed [2*DATA_W-1:0] in_sq;
  logic signed [DATA_W+Q_W:0] prod;

  logic [DATA_W-1:0] buf_mem [MAX_LEN];

  assign in_ready = (state == ACCUM);
  assign busy     = !((state == ACCUM) && (cnt == '0));
  assign in_hs    = in_valid && in_ready;
  assign last_in  = in_last || (cnt == LEN_W'(MAX_LEN - 1));
  assign in_sq    = $signed(in_data) * $signed(in_data);
  assign sq_ext   = ACC_W'($unsigned(in_sq));
  assign acc_sum  = acc + sq_ext;
  assign adv      = !out_valid || out_ready;
  assign rd_en    = (state == EMIT) && adv && (rd_idx < len);
  assign prod     = $signed(rd_dat) * $signed({1'b0, recip});

  // Non-restoring sqrt step: remainder stays signed, root bit is the sign of the new remainder.
  always_comb begin
    r_sh   = (sq_r << 2) | R_W'(sq_d[ACC_W-1 -: 2]);
    r_new  = sq_r[R_W-1] ? (r_sh + R_W'({sq_q, 2'b11})) : (r_sh - R_W'({sq_q, 2'b01}));
    q_new  = (sq_q << 1) | ROOT_W'(!r_new[R_W-1]);
    rem_sh = (rem << 1) | REM_W'(it == '0);
  end

  always_ff @(posedge clk) begin
    if (in_hs) buf_mem[cnt[ADDR_W-1:0]] <= in_data;
    if (rd_en) rd_dat <= buf_mem[rd_idx[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      len       <= '0;
      rd_idx    <= '0;
      sq_d      <= '0;
      sq_r      <= '0;
      sq_q      <= '0;
      norm      <= '0;
      rem       <= '0;
      recip     <= '0;
      it        <= '0;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      zero_norm <= 1'b0;
`ifdef FROBNORM_NORM_OUT_EN
      norm_out   <= '0;
      norm_valid <= 1'b0;
`endif
    end else begin
`ifdef FROBNORM_NORM_OUT_EN
      norm_valid <= 1'b0;
`endif
      case (state)
        ACCUM: if (in_hs) begin
          acc <= acc_sum;
          cnt <= cnt + LEN_W'(1);
          if (last_in) begin
            len       <= cnt + LEN_W'(1);
            overflow  <= !in_last;
            zero_norm <= 1'b0;
            sq_d      <= acc_sum;
            sq_r      <= '0;
            sq_q      <= '0;
            it        <= '0;
            state     <= SQRT;
          end
        end
        SQRT: begin
          sq_d <= sq_d << 2;
          sq_r <= r_new;
          sq_q <= q_new;
          it   <= it + IT_W'(1);
          if (it == IT_W'(ROOT_W - 1)) begin
            norm  <= q_new;
            it    <= '0;
            rem   <= '0;
            recip <= '0;
`ifdef FROBNORM_NORM_OUT_EN
            norm_out   <= q_new;
            norm_valid <= 1'b1;
`endif
            if (q_new == '0) begin
              zero_norm <= 1'b1;
              rd_idx    <= '0;
              s1_vld    <= 1'b0;
              state     <= EMIT;
            end else begin
              state <= RECIP;
            end
          end
        end
        RECIP: begin
          it <= it + IT_W'(1);
          // Dividend is a single 1 at its MSB, so only the first shifted-in bit is set.
          if (rem_sh >= {1'b0, norm}) begin
            rem   <= rem_sh - {1'b0, norm};
            recip <= {recip[Q_W-2:0], 1'b1};
          end else begin
            rem   <= rem_sh;
            recip <= {recip[Q_W-2:0], 1'b0};
          end
          if (it == IT_W'(Q_W - 1)) begin
            rd_idx <= '0;
            s1_vld <= 1'b0;
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (adv) begin
            if (rd_idx < len) begin
              s1_vld  <= 1'b1;
              s1_last <= (rd_idx == len - LEN_W'(1));
              rd_idx  <= rd_idx + LEN_W'(1);
            end else begin
              s1_vld <= 1'b0;
            end
            out_valid <= s1_vld;
            out_last  <= s1_last;
            if (s1_vld) out_data <= DATA_W'(prod >>> ROOT_W);
          end
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            s1_vld    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_frobenius_norm_stream.sv
// Self-checking bench for frobenius_norm_stream against a plain-arithmetic reference model.
module tb_frobenius_norm_stream;
  localparam int DW = 16;
  localparam int RW = 21;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last, busy, overflow, zero_norm;
  logic [DW-1:0] out_data;
`ifdef FROBNORM_NORM_OUT_EN
  logic [RW-1:0] norm_out;
  logic          norm_valid;
`endif

  int     vec = 0, err = 0, cyc = 0, hs_cyc = 0, first_cyc = 0, last_cyc = 0, n_acc = 0;
  int     tq[$];
  int     eq[$];
  bit     el[$];
  longint exp_norm = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frobenius_norm_stream #(.DATA_W(16), .MAX_LEN(256)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .overflow(overflow), .zero_norm(zero_norm)
`ifdef FROBNORM_NORM_OUT_EN
    , .norm_out(norm_out), .norm_valid(norm_valid)
`endif
  );

  function automatic longint isqrt(input longint s);
    longint r, t;
    r = 0;
    for (int b = RW - 1; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= s) r = t;
    end
    return r;
  endfunction

  function automatic void model(input int from, input int n);
    longint s, rc;
    s = 0;
    for (int i = from; i < from + n; i++) s += longint'(tq[i]) * longint'(tq[i]);
    exp_norm = isqrt(s);
    rc = (exp_norm == 0) ? 0 : (longint'(1) << (DW - 2 + RW)) / exp_norm;
    for (int i = from; i < from + n; i++) begin
      eq.push_back(int'((longint'(tq[i]) * rc) >>> RW));
      el.push_back(i == from + n - 1);
    end
  endfunction

  task automatic drive(input int from, input int n, input bit with_last, output bit ok);
    int guard;
    ok = 1'b1;
    for (int i = from; i < from + n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(tq[i]);
      in_last  = with_last && (i == from + n - 1);
      guard = 0;
      while (in_ready !== 1'b1 && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      if (in_ready !== 1'b1) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    hs_cyc   = cyc;
  endtask

  task automatic collect(input string name, input int n, input int mode);
    int got, guard, e;
    bit stalled, rdy, l;
    logic [DW-1:0] hd;
    logic hl;
    got = 0; guard = 0; stalled = 1'b0; first_cyc = -1; hd = '0; hl = 1'b0;
    while (got < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (stalled) begin
        vec++;
        if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) begin
          err++;
          $display("FAIL %s stall_hold got valid=%b data=%0d last=%b want valid=1 data=%0d last=%b",
                   name, out_valid, $signed(out_data), out_last, $signed(hd), hl);
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = guard[0];
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      out_ready = rdy;
      stalled = 1'b0;
      if (out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (rdy) begin
          e = eq.pop_front();
          l = el.pop_front();
          vec++;
          if (int'($signed(out_data)) !== e) begin
            err++;
            $display("FAIL %s data[%0d] got %0d want %0d", name, got, $signed(out_data), e);
          end
          vec++;
          if (out_last !== l) begin
            err++;
            $display("FAIL %s last[%0d] got %b want %b", name, got, out_last, l);
          end
          got++;
          last_cyc = cyc;
        end else begin
          stalled = 1'b1;
          hd = out_data;
          hl = out_last;
        end
      end
    end
    out_ready = 1'b1;
    if (got < n) begin
      vec++; err++;
      $display("FAIL %s output timeout got %0d elements want %0d", name, got, n);
      eq.delete(); el.delete();
    end
  endtask

  task automatic send(input string name, input int n, input int mode);
    bit ok;
    model(0, n);
    drive(0, n, 1'b1, ok);
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL %s input accept timeout", name);
    end
    collect(name, n, mode);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      err++;
      $display("FAIL %s idle_after got in_ready=%b out_valid=%b busy=%b want 1 0 0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vec++; if (in_ready !== 1'b1)  begin err++; $display("FAIL rst in_ready got %b want 1", in_ready); end
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst out_valid got %b want 0", out_valid); end
    vec++; if (out_data !== '0)    begin err++; $display("FAIL rst out_data got %0d want 0", out_data); end
    vec++; if (out_last !== 1'b0)  begin err++; $display("FAIL rst out_last got %b want 0", out_last); end
    vec++; if (busy !== 1'b0)      begin err++; $display("FAIL rst busy got %b want 0", busy); end
    vec++; if (overflow !== 1'b0)  begin err++; $display("FAIL rst overflow got %b want 0", overflow); end
    vec++; if (zero_norm !== 1'b0) begin err++; $display("FAIL rst zero_norm got %b want 0", zero_norm); end
`ifdef FROBNORM_NORM_OUT_EN
    vec++; if (norm_out !== '0) begin err++; $display("FAIL rst norm_out got %0d want 0", norm_out); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int want_lat;
    tq = '{3, 4};
    send("basic", 2, 0);
    want_lat = (exp_norm == 0) ? (2 + RW) : (2 + RW + RW + DW - 1);
    vec++;
    if (first_cyc - hs_cyc !== want_lat) begin
      err++; $display("FAIL basic latency got %0d want %0d", first_cyc - hs_cyc, want_lat);
    end
    vec++;
    if (last_cyc - first_cyc !== 1) begin
      err++; $display("FAIL basic bubble span got %0d want 1", last_cyc - first_cyc);
    end
    vec++;
    if (overflow !== 1'b0 || zero_norm !== 1'b0) begin
      err++; $display("FAIL basic flags got ovf=%b zn=%b want 0 0", overflow, zero_norm);
    end
`ifdef FROBNORM_NORM_OUT_EN
    vec++;
    if (longint'(norm_out) !== exp_norm) begin
      err++; $display("FAIL basic norm_out got %0d want %0d", norm_out, exp_norm);
    end
`endif
    check_idle("basic");
  endtask

  task automatic test_signed;
    tq = '{-3, 4};
    send("neg_pair", 2, 0);
    tq.delete(); tq.push_back(-7);
    send("single_neg", 1, 0);
    tq.delete(); tq.push_back(7);
    send("single_pos", 1, 0);
    check_idle("signed");
  endtask

  task automatic test_zero;
    int want_lat;
    tq = '{0, 0, 0};
    send("zero", 3, 0);
    want_lat = (exp_norm == 0) ? (2 + RW) : (2 + RW + RW + DW - 1);
    vec++;
    if (first_cyc - hs_cyc !== want_lat) begin
      err++; $display("FAIL zero latency got %0d want %0d", first_cyc - hs_cyc, want_lat);
    end
    vec++;
    if (zero_norm !== 1'b1) begin
      err++; $display("FAIL zero zero_norm got %b want 1", zero_norm);
    end
`ifdef FROBNORM_NORM_OUT_EN
    vec++;
    if (longint'(norm_out) !== exp_norm) begin
      err++; $display("FAIL zero norm_out got %0d want %0d", norm_out, exp_norm);
    end
`endif
    check_idle("zero");
  endtask

  task automatic test_overflow;
    bit ok;
    int span, g;
    tq.delete();
    for (int i = 0; i < 300; i++) tq.push_back(1);
    model(0, 256);
    model(256, 44);
    n_acc = 0;
    span = -1;
    fork
      drive(0, 300, 1'b1, ok);
      begin
        collect("ovf_a", 256, 0);
        span = last_cyc - first_cyc;
        collect("ovf_b", 44, 0);
      end
      begin
        g = 0;
        @(negedge clk);
        while (in_ready === 1'b1 && g < 1000) begin
          @(negedge clk);
          g++;
        end
        vec++;
        if (in_ready !== 1'b0 || n_acc !== 256) begin
          err++; $display("FAIL ovf truncate got in_ready=%b accepted=%0d want 0 256", in_ready, n_acc);
        end
        vec++;
        if (overflow !== 1'b1 || zero_norm !== 1'b0) begin
          err++; $display("FAIL ovf flags got ovf=%b zn=%b want 1 0", overflow, zero_norm);
        end
      end
    join
    vec++;
    if (!ok) begin err++; $display("FAIL ovf input accept timeout"); end
    vec++;
    if (span !== 255) begin err++; $display("FAIL ovf bubble span got %0d want 255", span); end
    vec++;
    if (overflow !== 1'b0) begin err++; $display("FAIL ovf next_tensor overflow got %b want 0", overflow); end
  endtask

  task automatic test_backpressure;
    tq = '{3, 4};
    send("bp_toggle", 2, 1);
    check_idle("bp_toggle");
  endtask

  task automatic test_random;
    int n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 40);
      tq.delete();
      for (int i = 0; i < n; i++) tq.push_back(int'($signed(16'($urandom))));
      if (t == 0) tq[0] = -32768;
      send("random", n, 2);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    tq = '{3, 4};
    drive(0, 2, 1'b1, ok);
    vec++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      err++; $display("FAIL mid busy got in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        busy !== 1'b0 || overflow !== 1'b0 || zero_norm !== 1'b0) begin
      err++;
      $display("FAIL mid_rst got rdy=%b vld=%b dat=%0d last=%b busy=%b ovf=%b zn=%b want 1 0 0 0 0 0 0",
               in_ready, out_valid, out_data, out_last, busy, overflow, zero_norm);
    end
    @(negedge clk);
    rst = 1'b0;
    send("after_rst", 2, 0);
    check_idle("after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_zero();
    test_overflow();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
